// File: rtl/image_ram_loader.sv
// Streams raster-ordered 12-bit RGB pixels into an image RAM and serves them back through a
// coordinate-addressed read port. Define IMAGE_LOADER_SOF_EN to add the in_sof resync input.
module image_ram_loader #(
    parameter int IMAGE_WIDTH  = 100,
    parameter int IMAGE_HEIGHT = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] in_data,
    input  logic        in_valid,
`ifdef IMAGE_LOADER_SOF_EN
    input  logic        in_sof,
`endif
    output logic        in_ready,
    output logic        busy,
    output logic        done,
    output logic        loaded,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic [9:0]  base_x,
    input  logic [9:0]  base_y,
    output logic [11:0] pixel_data,
    output logic        valid
);

    localparam int DEPTH = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [9:0] LAST_X = 10'(IMAGE_WIDTH - 1);
    localparam logic [9:0] LAST_Y = 10'(IMAGE_HEIGHT - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [9:0]  wr_x_q, wr_x_d, wr_y_q, wr_y_d;
    logic        loaded_q, loaded_d;
    logic        done_q, done_d;
    logic        valid_q, valid_d;
    logic [11:0] ram_rd_q;
    logic [11:0] mem [DEPTH];

    logic          beat, sof, last_beat, in_image;
    logic [9:0]    cur_x, cur_y;
    logic [AW-1:0] wr_addr, rd_addr;

`ifdef IMAGE_LOADER_SOF_EN
    assign sof = in_sof;
`else
    assign sof = 1'b0;
`endif

    // A start-of-frame beat is treated as the beat at (0,0) regardless of the counters.
    assign beat      = in_valid && in_ready;
    assign cur_x     = sof ? 10'd0 : wr_x_q;
    assign cur_y     = sof ? 10'd0 : wr_y_q;
    assign last_beat = (cur_x == LAST_X) && (cur_y == LAST_Y);
    assign wr_addr   = AW'(cur_y) * AW'(IMAGE_WIDTH) + AW'(cur_x);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_LOAD;
            S_LOAD:         if (beat && last_beat) state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == S_LOAD);
        busy     = (state_q == S_LOAD);
    end

    always_comb begin
        wr_x_d   = wr_x_q;
        wr_y_d   = wr_y_q;
        loaded_d = loaded_q;
        done_d   = 1'b0;
        if (state_q != S_LOAD && start) begin
            wr_x_d   = 10'd0;
            wr_y_d   = 10'd0;
            loaded_d = 1'b0;
        end else if (beat) begin
            if (cur_x == LAST_X) begin
                wr_x_d = 10'd0;
                wr_y_d = last_beat ? 10'd0 : cur_y + 10'd1;
            end else begin
                wr_x_d = cur_x + 10'd1;
                wr_y_d = cur_y;
            end
            if (last_beat) begin
                done_d   = 1'b1;
                loaded_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_x_q   <= 10'd0;
            wr_y_q   <= 10'd0;
            loaded_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            wr_x_q   <= wr_x_d;
            wr_y_q   <= wr_y_d;
            loaded_q <= loaded_d;
            done_q   <= done_d;
        end
    end

    assign done   = done_q;
    assign loaded = loaded_q;

    // Read port: bounds are checked at 11 bits so base+width cannot wrap.
    assign in_image = ({1'b0, x} >= {1'b0, base_x}) &&
                      ({1'b0, x} <  {1'b0, base_x} + 11'(IMAGE_WIDTH)) &&
                      ({1'b0, y} >= {1'b0, base_y}) &&
                      ({1'b0, y} <  {1'b0, base_y} + 11'(IMAGE_HEIGHT));
    assign rd_addr  = AW'(y - base_y) * AW'(IMAGE_WIDTH) + AW'(x - base_x);
    assign valid_d  = in_image && loaded_q;

    // Plain write port plus unconditional registered read keeps this a simple dual-port BRAM;
    // the old word is returned on a same-address collision.
    always_ff @(posedge clk) begin
        if (beat) mem[wr_addr] <= in_data;
        ram_rd_q <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) valid_q <= 1'b0;
        else     valid_q <= valid_d;
    end

    assign valid      = valid_q;
    assign pixel_data = valid_q ? ram_rd_q : 12'h000;

endmodule

// File: tb/tb_image_ram_loader.sv
// Directed bench for image_ram_loader with a 4x2 image placed at (10,20).
module tb_image_ram_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] in_data = 12'h000;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic        in_ready, busy, done, loaded, valid;
    logic [9:0]  x = 10'd0, y = 10'd0;
    logic [9:0]  base_x = 10'd10, base_y = 10'd20;
    logic [11:0] pixel_data;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    image_ram_loader #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(2)) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
`ifdef IMAGE_LOADER_SOF_EN
        .in_sof(in_sof),
`endif
        .in_ready(in_ready), .busy(busy), .done(done), .loaded(loaded),
        .x(x), .y(y), .base_x(base_x), .base_y(base_y),
        .pixel_data(pixel_data), .valid(valid)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int px, input int py);
        x = 10'(px);
        y = 10'(py);
        step();
    endtask

    // Drives start plus 8 beats of base+i; reports cycles spent on beats, done pulses seen
    // (including one trailing cycle) and the beat-cycle index at which done was observed.
    task automatic do_load(input logic [11:0] base, input bit gap, input bit start_last,
                           output int ncyc, output int ndone, output int done_at);
        ncyc = 0; ndone = 0; done_at = -1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (gap) begin
                in_valid = 1'b0;
                in_data  = 12'hFFF;
                step();
                ncyc++;
                if (done) begin ndone++; done_at = ncyc; end
            end
            in_valid = 1'b1;
            in_data  = base + 12'(i);
            if (start_last && i == 7) start = 1'b1;
            step();
            ncyc++;
            if (done) begin ndone++; done_at = ncyc; end
        end
        in_valid = 1'b0;
        start    = 1'b0;
        step();
        if (done) ndone++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (loaded !== 1'b0) begin bad++; $display("FAIL reset_loaded got=%b want=0", loaded); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
        total++; if (pixel_data !== 12'h000) begin bad++; $display("FAIL reset_pixel got=%h want=000", pixel_data); end
    endtask

    task automatic test_full_load();
        int nc, nd, da;
        start = 1'b1;
        step();
        start = 1'b0;
        total++; if (in_ready !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL load_ready got=%b%b want=11", in_ready, busy); end
        rst = 1'b1; step(); rst = 1'b0;
        do_load(12'h001, 1'b0, 1'b0, nc, nd, da);
        total++; if (nd !== 1) begin bad++; $display("FAIL full_done_pulses got=%0d want=1", nd); end
        total++; if (da !== 8) begin bad++; $display("FAIL full_done_cycle got=%0d want=8", da); end
        total++; if (loaded !== 1'b1) begin bad++; $display("FAIL full_loaded got=%b want=1", loaded); end
        total++; if (in_ready !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL full_idle got=%b%b want=00", in_ready, busy); end
        rd(11, 21);
        total++; if (pixel_data !== 12'h006) begin bad++; $display("FAIL full_read got=%h want=006", pixel_data); end
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL full_valid got=%b want=1", valid); end
    endtask

    task automatic test_gaps();
        int nc, nd, da;
        do_load(12'h001, 1'b1, 1'b0, nc, nd, da);
        total++; if (nc !== 16 || da !== 16 || nd !== 1) begin bad++; $display("FAIL gaps_timing got=%0d/%0d/%0d want=16/16/1", nc, da, nd); end
        for (int a = 0; a < 8; a++) begin
            rd(10 + a % 4, 20 + a / 4);
            total++;
            if (pixel_data !== 12'(a + 1) || valid !== 1'b1) begin
                bad++; $display("FAIL gaps_read%0d got=%h/%b want=%h/1", a, pixel_data, valid, 12'(a + 1));
            end
        end
    endtask

    task automatic test_reset_mid_load();
        int nc, nd, da;
        x = 10'd12; y = 10'd20;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 12'h055; step();
        end
        in_valid = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;
        total++; if (loaded !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL midrst_state got=%b%b%b want=000", loaded, busy, in_ready); end
        rd(12, 20);
        total++; if (valid !== 1'b0 || pixel_data !== 12'h000) begin bad++; $display("FAIL midrst_read got=%b/%h want=0/000", valid, pixel_data); end
        do_load(12'h0A0, 1'b0, 1'b0, nc, nd, da);
        total++; if (nd !== 1 || da !== 8) begin bad++; $display("FAIL midrst_done got=%0d@%0d want=1@8", nd, da); end
        rd(10, 20);
        total++; if (pixel_data !== 12'h0A0 || valid !== 1'b1) begin bad++; $display("FAIL midrst_read0 got=%h/%b want=0a0/1", pixel_data, valid); end
        rd(13, 21);
        total++; if (pixel_data !== 12'h0A7) begin bad++; $display("FAIL midrst_read7 got=%h want=0a7", pixel_data); end
    endtask

    task automatic test_bounds_and_unloaded();
        int nc, nd, da;
        rd(14, 20);
        total++; if (valid !== 1'b0 || pixel_data !== 12'h000) begin bad++; $display("FAIL oob_right got=%b/%h want=0/000", valid, pixel_data); end
        rd(9, 21);
        total++; if (valid !== 1'b0 || pixel_data !== 12'h000) begin bad++; $display("FAIL oob_left got=%b/%h want=0/000", valid, pixel_data); end
        rd(10, 22);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL oob_below got=%b want=0", valid); end
        rd(11, 19);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL oob_above got=%b want=0", valid); end
        start = 1'b1; step(); start = 1'b0;
        total++; if (loaded !== 1'b0) begin bad++; $display("FAIL reload_loaded got=%b want=0", loaded); end
        rd(10, 20);
        total++; if (valid !== 1'b0 || pixel_data !== 12'h000) begin bad++; $display("FAIL reload_read got=%b/%h want=0/000", valid, pixel_data); end
        rst = 1'b1; step(); rst = 1'b0;
        // Start arriving with the last beat must be ignored: loader ends up idle, not reloading.
        do_load(12'h300, 1'b0, 1'b1, nc, nd, da);
        total++; if (in_ready !== 1'b0 || loaded !== 1'b1) begin bad++; $display("FAIL start_last got=%b/%b want=0/1", in_ready, loaded); end
        rd(12, 21);
        total++; if (pixel_data !== 12'h306) begin bad++; $display("FAIL start_last_read got=%h want=306", pixel_data); end
    endtask

`ifdef IMAGE_LOADER_SOF_EN
    task automatic test_sof();
        logic [11:0] vals [10];
        int nd = 0;
        int da = -1;
        vals = '{12'h111, 12'h222, 12'h333, 12'h444, 12'h555, 12'h666,
                 12'h777, 12'h888, 12'h999, 12'h9A9};
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_sof   = (i == 2);
            in_data  = vals[i];
            step();
            if (done) begin nd++; da = i; end
        end
        in_valid = 1'b0; in_sof = 1'b0;
        step();
        if (done) nd++;
        total++; if (nd !== 1 || da !== 9) begin bad++; $display("FAIL sof_done got=%0d@%0d want=1@9", nd, da); end
        rd(10, 20);
        total++; if (pixel_data !== 12'h333) begin bad++; $display("FAIL sof_addr0 got=%h want=333", pixel_data); end
        rd(11, 20);
        total++; if (pixel_data !== 12'h444) begin bad++; $display("FAIL sof_addr1 got=%h want=444", pixel_data); end
        rd(13, 21);
        total++; if (pixel_data !== 12'h9A9) begin bad++; $display("FAIL sof_addr7 got=%h want=9a9", pixel_data); end
    endtask
`endif

    initial begin
        test_reset();
        test_full_load();
        test_gaps();
        test_reset_mid_load();
        test_bounds_and_unloaded();
`ifdef IMAGE_LOADER_SOF_EN
        test_sof();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
